// File: rtl/tpg_stream_sink.sv
// tpg_stream_sink: Avalon-ST video sink and frame checker.
// Consumes the pattern generator's pixel stream through valid/ready, drives
// ready_o from a selectable backpressure pattern, and for every frame checks the
// pixel count against width*height and folds the pixels into a rotate-xor checksum.
module tpg_stream_sink #(
    parameter int          DATA_WIDTH = 24,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  enable_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  end_of_video_i,
    output logic                  ready_o,
    input  logic [1:0]            bp_mode_i,
    input  logic [31:0]           width_i,
    input  logic [31:0]           height_i,
    output logic                  frame_done_o,
    output logic                  frame_ok_o,
    output logic [31:0]           pix_cnt_o,
    output logic [31:0]           checksum_o,
    output logic [15:0]           frame_cnt_o,
    output logic [15:0]           err_cnt_o,
    output logic [1:0]            state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] lfsr;
    logic [1:0]  phase;
    logic [31:0] pix;
    logic [31:0] sum;
    logic [31:0] exp_pix;

    logic [15:0] lfsr_nxt;
    logic [1:0]  phase_nxt;
    logic        bp_rdy;
    logic        xfer;
    logic [31:0] data_ext;
    logic [31:0] pix_inc;
    logic [31:0] sum_upd;
    logic [31:0] exp_new;

    // Only the low halves of the size inputs matter.
    logic unused_size_hi;
    assign unused_size_hi = ^{width_i[31:16], height_i[31:16]};

    assign state_o = state;

    // Next pattern state and per-transfer arithmetic. ready_o is registered from
    // the next LFSR/phase values so a mode change shows on the next cycle.
    always_comb begin
        lfsr_nxt  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        phase_nxt = phase + 2'd1;
        case (bp_mode_i)
            2'd0:    bp_rdy = 1'b1;
            2'd1:    bp_rdy = lfsr_nxt[0];
            2'd2:    bp_rdy = (phase_nxt == 2'd3);
            default: bp_rdy = 1'b0;
        endcase
        xfer     = valid_i && ready_o;
        data_ext = 32'(data_i);
        // Overlong frames stop counting at all-ones and are judged at their close.
        pix_inc  = (pix == 32'hFFFF_FFFF) ? pix : pix + 32'd1;
        sum_upd  = {sum[30:0], sum[31]} ^ data_ext;
        exp_new  = {16'd0, width_i[15:0]} * {16'd0, height_i[15:0]};
    end

    // Sync/run state machine, pattern generators, frame accumulation and results.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state        <= IDLE;
            lfsr         <= LFSR_SEED;
            phase        <= 2'd0;
            ready_o      <= 1'b0;
            pix          <= 32'd0;
            sum          <= 32'd0;
            exp_pix      <= 32'd0;
            frame_done_o <= 1'b0;
            frame_ok_o   <= 1'b0;
            pix_cnt_o    <= 32'd0;
            checksum_o   <= 32'd0;
            frame_cnt_o  <= 16'd0;
            err_cnt_o    <= 16'd0;
        end else begin
            frame_done_o <= 1'b0;
            if (state == IDLE) begin
                ready_o <= 1'b0;
                if (enable_i) begin
                    state <= SYNC;
                    lfsr  <= LFSR_SEED;
                    phase <= 2'd0;
                end
            end else if (!enable_i) begin
                // Any partial frame is dropped; results and counters hold.
                state   <= IDLE;
                ready_o <= 1'b0;
            end else begin
                lfsr    <= lfsr_nxt;
                phase   <= phase_nxt;
                ready_o <= bp_rdy;
                case (state)
                    SYNC: begin
                        // Discard pixels until a frame boundary is seen.
                        if (xfer && end_of_video_i) begin
                            state   <= RUN;
                            pix     <= 32'd0;
                            sum     <= 32'd0;
                            exp_pix <= exp_new;
                        end
                    end
                    RUN: begin
                        if (xfer) begin
                            if (end_of_video_i) begin
                                frame_done_o <= 1'b1;
                                frame_ok_o   <= (pix_inc == exp_pix);
                                pix_cnt_o    <= pix_inc;
                                checksum_o   <= sum_upd;
                                frame_cnt_o  <= frame_cnt_o + 16'd1;
                                if (pix_inc != exp_pix && err_cnt_o != 16'hFFFF)
                                    err_cnt_o <= err_cnt_o + 16'd1;
                                pix     <= 32'd0;
                                sum     <= 32'd0;
                                exp_pix <= exp_new;
                            end else begin
                                pix <= pix_inc;
                                sum <= sum_upd;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tpg_stream_sink.sv
// tb_tpg_stream_sink: randomized frames into tpg_stream_sink. The generator side
// records each frame's expected result in a queue; a monitor pops and compares
// whenever frame_done_o pulses.
module tb_tpg_stream_sink;

    localparam int DW = 24;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          enable_i;
    logic          valid_i;
    logic [DW-1:0] data_i;
    logic          end_of_video_i;
    logic          ready_o;
    logic [1:0]    bp_mode_i;
    logic [31:0]   width_i;
    logic [31:0]   height_i;
    logic          frame_done_o;
    logic          frame_ok_o;
    logic [31:0]   pix_cnt_o;
    logic [31:0]   checksum_o;
    logic [15:0]   frame_cnt_o;
    logic [15:0]   err_cnt_o;
    logic [1:0]    state_o;

    tpg_stream_sink #(.DATA_WIDTH(DW), .LFSR_SEED(16'hACE1)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .enable_i(enable_i),
        .valid_i(valid_i), .data_i(data_i), .end_of_video_i(end_of_video_i),
        .ready_o(ready_o), .bp_mode_i(bp_mode_i), .width_i(width_i),
        .height_i(height_i), .frame_done_o(frame_done_o), .frame_ok_o(frame_ok_o),
        .pix_cnt_o(pix_cnt_o), .checksum_o(checksum_o), .frame_cnt_o(frame_cnt_o),
        .err_cnt_o(err_cnt_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pix;
        logic [31:0] sum;
        logic        ok;
        logic [15:0] fcnt;
        logic [15:0] ecnt;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          m_fcnt = 0;
    int          m_ecnt = 0;
    logic [31:0] m_exp  = 32'd0;   // expected size latched at the previous frame boundary

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Present one pixel and hold it until accepted (ready_o seen at the negedge
    // means the transfer happens at the following rising edge).
    task automatic send_pix(input logic [DW-1:0] d, input bit eop, input bit gaps);
        int w;
        if (gaps && $urandom_range(0, 3) == 0) begin
            valid_i = 1'b0;
            @(negedge clk_i);
        end
        valid_i = 1'b1; data_i = d; end_of_video_i = eop;
        w = 0;
        while (ready_o !== 1'b1 && w < 1000) begin
            @(negedge clk_i);
            w++;
        end
        if (w >= 1000) begin
            checks++; errors++;
            $display("FAIL ready_timeout waited=%0d required ready_o=1", w);
        end else begin
            @(negedge clk_i);
        end
        valid_i = 1'b0; end_of_video_i = 1'b0;
    endtask

    // Send an n-pixel frame, eop on the last pixel. counted=0 for the frame
    // that only synchronises the sink.
    task automatic send_frame(input int n, input bit counted, input bit fixed, input bit gaps);
        logic [DW-1:0] px[$];
        logic [31:0]   s;
        exp_t          e;
        s = 32'd0;
        for (int i = 0; i < n; i++) begin
            if (fixed) px.push_back(DW'(i + 1));
            else       px.push_back(DW'($urandom));
        end
        if (counted) begin
            foreach (px[i]) s = {s[30:0], s[31]} ^ {8'd0, px[i]};
            m_fcnt = (m_fcnt + 1) % 65536;
            if (n != m_exp && m_ecnt < 65535) m_ecnt++;
            e.pix = n; e.sum = s; e.ok = (n == m_exp);
            e.fcnt = 16'(m_fcnt); e.ecnt = 16'(m_ecnt);
            sb.push_back(e);
        end
        foreach (px[i]) send_pix(px[i], i == n - 1, gaps);
        m_exp = width_i[15:0] * height_i[15:0];
    endtask

    // Monitor: every frame_done_o pulse must match the oldest expected frame.
    always @(negedge clk_i) begin
        if (reset_n_i === 1'b1 && frame_done_o === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_frame_done", {31'd0, frame_done_o}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pix_cnt",   pix_cnt_o,            e.pix);
                chk("checksum",  checksum_o,           e.sum);
                chk("frame_ok",  {31'd0, frame_ok_o},  {31'd0, e.ok});
                chk("frame_cnt", {16'd0, frame_cnt_o}, {16'd0, e.fcnt});
                chk("err_cnt",   {16'd0, err_cnt_o},   {16'd0, e.ecnt});
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"},  {31'd0, ready_o},      32'd0);
        chk({tag, "_done"},   {31'd0, frame_done_o}, 32'd0);
        chk({tag, "_ok"},     {31'd0, frame_ok_o},   32'd0);
        chk({tag, "_pix"},    pix_cnt_o,             32'd0);
        chk({tag, "_sum"},    checksum_o,            32'd0);
        chk({tag, "_fcnt"},   {16'd0, frame_cnt_o},  32'd0);
        chk({tag, "_ecnt"},   {16'd0, err_cnt_o},    32'd0);
        chk({tag, "_state"},  {30'd0, state_o},      32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int ones;
        reset_n_i = 1'b0; enable_i = 1'b0; valid_i = 1'b0; data_i = '0;
        end_of_video_i = 1'b0; bp_mode_i = 2'd0; width_i = 32'd4; height_i = 32'd2;
        tick(2);
        chk_reset_vals("reset");
        reset_n_i = 1'b1;
        tick(1);

        // Enable: SYNC after the first edge, pattern-driven ready after the second.
        enable_i = 1'b1;
        tick(1);
        chk("enable_state_sync", {30'd0, state_o}, 32'd1);
        chk("enable_ready_first", {31'd0, ready_o}, 32'd0);
        tick(1);
        chk("enable_ready_second", {31'd0, ready_o}, 32'd1);

        // Sync frame, then the reference frame 1..8.
        send_frame(3, 1'b0, 1'b0, 1'b0);
        send_frame(8, 1'b1, 1'b1, 1'b0);
        tick(2);
        chk("ref_checksum", checksum_o, 32'h16);
        chk("ref_pix", pix_cnt_o, 32'd8);

        // Short, correct, long frames back-to-back with random gaps.
        send_frame(6, 1'b1, 1'b0, 1'b1);
        send_frame(8, 1'b1, 1'b0, 1'b0);
        send_frame(11, 1'b1, 1'b0, 1'b1);

        // Stall mode: a pending pixel must never be taken.
        bp_mode_i = 2'd3;
        tick(1);
        valid_i = 1'b1; end_of_video_i = 1'b1; data_i = 24'h5A5A5A;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("stall_ready", {31'd0, ready_o}, 32'd0);
        end
        valid_i = 1'b0; end_of_video_i = 1'b0;
        bp_mode_i = 2'd0;
        tick(1);
        chk("mode_change_ready", {31'd0, ready_o}, 32'd1);

        // Single-pixel frames; the first still uses the previously latched size.
        width_i = 32'd1; height_i = 32'd1;
        for (int i = 0; i < 4; i++) send_frame(1, 1'b1, 1'b0, 1'b0);

        // Random backpressure, then one-in-four.
        width_i = 32'hABCD_0006; height_i = 32'h1234_0008;
        bp_mode_i = 2'd1;
        for (int i = 0; i < 3; i++) send_frame(48, 1'b1, 1'b0, 1'b1);
        bp_mode_i = 2'd2;
        tick(1);
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (ready_o === 1'b1) ones++;
        end
        chk("mode2_ready_ratio", ones, 32'd4);
        for (int i = 0; i < 2; i++) send_frame(48, 1'b1, 1'b0, 1'b0);

        // Enable dropped mid-frame: partial frame discarded, then resync.
        bp_mode_i = 2'd0;
        for (int i = 0; i < 3; i++) send_pix(DW'($urandom), 1'b0, 1'b0);
        enable_i = 1'b0;
        tick(1);
        chk("disable_state", {30'd0, state_o}, 32'd0);
        chk("disable_ready", {31'd0, ready_o}, 32'd0);
        chk("disable_fcnt", {16'd0, frame_cnt_o}, m_fcnt);
        tick(2);
        enable_i = 1'b1;
        tick(1);
        chk("reenable_state", {30'd0, state_o}, 32'd1);
        send_frame(5, 1'b0, 1'b0, 1'b0);
        send_frame(48, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a frame.
        for (int i = 0; i < 3; i++) send_pix(DW'($urandom), 1'b0, 1'b0);
        reset_n_i = 1'b0;
        #1;
        chk_reset_vals("midreset");
        tick(1);
        reset_n_i = 1'b1;
        m_fcnt = 0; m_ecnt = 0;
        tick(2);
        chk("post_reset_state", {30'd0, state_o}, 32'd1);
        send_frame(2, 1'b0, 1'b0, 1'b0);
        send_frame(48, 1'b1, 1'b0, 1'b1);
        send_frame(47, 1'b1, 1'b0, 1'b0);

        tick(5);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
